// File: rtl/noc_mux_rr_pkg.sv
// -----------------------------------------------------------------------------
// noc_mux_rr_pkg
// Shared definitions for the round-robin NoC packet multiplexer:
//   - state_e  : arbitration FSM state (IDLE = searching, LOCKED = mid-packet)
//   - ch_idx_w : width of a channel index for a given channel count
// -----------------------------------------------------------------------------
package noc_mux_rr_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Channel index width; never less than one bit so a 1-bit index exists
    // even for degenerate channel counts.
    function automatic int ch_idx_w(input int channels);
        if (channels <= 2) begin
            return 1;
        end else begin
            return $clog2(channels);
        end
    endfunction

endpackage : noc_mux_rr_pkg

// File: rtl/noc_arb_rr.sv
// -----------------------------------------------------------------------------
// noc_arb_rr
// Purely combinational round-robin arbiter. Grants the first requesting
// channel found searching upward from i_rr_ptr, wrapping from CHANNELS-1 to 0.
//
// Ports:
//   i_req     [CHANNELS]  request vector (one bit per channel)
//   i_rr_ptr  [IDX_W]     channel with highest priority this cycle
//   o_grant   [CHANNELS]  one-hot grant, all zero when nothing requests
// -----------------------------------------------------------------------------
module noc_arb_rr #(
    parameter int CHANNELS = 4,
    parameter int IDX_W    = 2
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [IDX_W-1:0]    i_rr_ptr,
    output logic [CHANNELS-1:0] o_grant
);

    localparam logic [CHANNELS-1:0] CH_ONE = {{(CHANNELS-1){1'b0}}, 1'b1};

    logic [CHANNELS-1:0] w_rot_req;
    logic [CHANNELS-1:0] w_rot_gnt;

    // Rotate requests so that the priority channel sits at bit 0; the doubled
    // vector makes the rotation a plain shift.
    assign w_rot_req = CHANNELS'({i_req, i_req} >> i_rr_ptr);

    // Isolate the lowest set bit: first requester at or above the pointer.
    assign w_rot_gnt = w_rot_req & ~(w_rot_req - CH_ONE);

    // Rotate the grant back to absolute channel positions.
    assign o_grant = CHANNELS'(({w_rot_gnt, w_rot_gnt} << i_rr_ptr) >> CHANNELS);

endmodule : noc_arb_rr

// File: rtl/noc_mux_rr.sv
// -----------------------------------------------------------------------------
// noc_mux_rr
// Packet-aware round-robin multiplexer: merges CHANNELS flit streams onto one
// output. Arbitration happens only at packet boundaries; once the first flit
// of a multi-flit packet transfers, the channel is locked until its last flit
// transfers, so packets are never interleaved.
//
// Build option:
//   NOC_MUX_RR_OUTREG_EN  defined   -> 2-entry output skid buffer, registered
//                                      outputs, 1-cycle latency, in_ready is
//                                      "buffer not full".
//                         undefined -> combinational datapath, 0-cycle
//                                      latency, in_ready follows out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_flit    CHANNELS*FLIT_WIDTH flat flits, channel i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   in_last    per-channel last-flit marker
//   in_valid   per-channel flit valid
//   in_ready   per-channel accept (at most one bit high)
//   out_flit   selected flit
//   out_last   last-flit marker of out_flit
//   out_valid  output valid
//   out_ready  downstream accept
//   active_ch  locked channel, or last granted channel
// -----------------------------------------------------------------------------
module noc_mux_rr
    import noc_mux_rr_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
    input  logic [CHANNELS-1:0]            in_last,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]          out_flit,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(CHANNELS)-1:0]    active_ch
);

    localparam int                  IDX_W  = ch_idx_w(CHANNELS);
    localparam logic [CHANNELS-1:0] CH_ONE = {{(CHANNELS-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]    IDX_MAX = IDX_W'(CHANNELS - 1);
    localparam logic [IDX_W-1:0]    IDX_ONE = IDX_W'(1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      w_rr_ptr_nxt;
    logic [IDX_W-1:0]      r_lock_ch;
    logic [IDX_W-1:0]      w_lock_ch_nxt;
    logic [IDX_W-1:0]      r_active_ch;
    logic [IDX_W-1:0]      w_active_ch_nxt;

    logic [CHANNELS-1:0]   w_arb_gnt;
    logic [IDX_W-1:0]      w_arb_idx;
    logic [CHANNELS-1:0]   w_lock_oh;
    logic [CHANNELS-1:0]   w_gnt;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [IDX_W-1:0]      w_ptr_inc;
    logic [FLIT_WIDTH-1:0] w_sel_flit;
    logic                  w_sel_last;
    logic                  w_sel_valid;
    logic                  w_accept;
    logic                  w_xfer;

    noc_arb_rr #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_arb (
        .i_req    (in_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_arb_gnt)
    );

    assign w_lock_oh = CH_ONE << r_lock_ch;

    // One-hot arbiter grant to channel index.
    always_comb begin
        w_arb_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_arb_idx = w_arb_idx | ({IDX_W{w_arb_gnt[i]}} & IDX_W'(i));
        end
    end

    // Grant source: fresh arbitration when idle, the latched channel when locked.
    always_comb begin
        w_gnt     = '0;
        w_sel_idx = '0;
        case (r_state)
            IDLE: begin
                w_gnt     = w_arb_gnt;
                w_sel_idx = w_arb_idx;
            end
            LOCKED: begin
                w_gnt     = w_lock_oh;
                w_sel_idx = r_lock_ch;
            end
            default: begin
                w_gnt     = '0;
                w_sel_idx = '0;
            end
        endcase
    end

    // AND-OR flit/last mux driven by the one-hot grant.
    always_comb begin
        w_sel_flit = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_sel_flit = w_sel_flit | (in_flit[i*FLIT_WIDTH +: FLIT_WIDTH] & {FLIT_WIDTH{w_gnt[i]}});
            w_sel_last = w_sel_last | (in_last[i] & w_gnt[i]);
        end
    end

    // rst_n gates the combinational handshake so nothing is offered or
    // accepted while reset is held, even with inputs valid.
    assign w_sel_valid = rst_n & (|(w_gnt & in_valid));
    assign w_xfer      = w_sel_valid & w_accept;
    assign in_ready    = w_gnt & {CHANNELS{w_accept}};
    assign w_ptr_inc   = (w_sel_idx == IDX_MAX) ? '0 : (w_sel_idx + IDX_ONE);

    // Next-state: lock on a non-last transfer, release and rotate on a last one.
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_lock_ch_nxt   = r_lock_ch;
        w_active_ch_nxt = r_active_ch;
        if (w_xfer) begin
            w_active_ch_nxt = w_sel_idx;
            if (w_sel_last) begin
                w_state_nxt  = IDLE;
                w_rr_ptr_nxt = w_ptr_inc;
            end else begin
                w_state_nxt   = LOCKED;
                w_lock_ch_nxt = w_sel_idx;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM, round-robin pointer, lock and active-channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_lock_ch   <= '0;
            r_active_ch <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_lock_ch   <= w_lock_ch_nxt;
            r_active_ch <= w_active_ch_nxt;
        end
    end

    assign active_ch = r_active_ch;

`ifdef NOC_MUX_RR_OUTREG_EN
    // Two-entry output stage: the output register plus one skid slot. The skid
    // slot only fills when the output register is stalled, so "full" is simply
    // "skid occupied", which keeps in_ready free of any out_ready path.
    logic [FLIT_WIDTH-1:0] r_out_flit;
    logic                  r_out_last;
    logic                  r_out_valid;
    logic [FLIT_WIDTH-1:0] r_skid_flit;
    logic                  r_skid_last;
    logic                  r_skid_valid;
    logic                  w_out_free;

    assign w_accept   = rst_n & ~r_skid_valid;
    assign w_out_free = ~r_out_valid | out_ready;

    // Output register and skid slot update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_flit   <= '0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_flit  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                // Skid full means nothing was accepted this cycle.
                r_out_flit   <= r_skid_flit;
                r_out_last   <= r_skid_last;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_xfer) begin
                r_out_flit  <= w_sel_flit;
                r_out_last  <= w_sel_last;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_xfer) begin
            r_skid_flit  <= w_sel_flit;
            r_skid_last  <= w_sel_last;
            r_skid_valid <= 1'b1;
        end else begin
            r_skid_valid <= r_skid_valid;
        end
    end

    assign out_flit  = r_out_flit;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
`else
    assign w_accept  = rst_n & out_ready;
    assign out_flit  = w_sel_flit;
    assign out_last  = w_sel_last;
    assign out_valid = w_sel_valid;
`endif

endmodule : noc_mux_rr

// File: tb/tb_noc_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_noc_mux_rr
// Directed bench for noc_mux_rr (4 channels, 32-bit flits). Per-channel source
// models feed packets; the expected output order is hand-computed and pushed
// into a scoreboard queue, and a monitor pops/compares on every output
// handshake. Flit payloads encode {scenario, channel, sequence}.
// Honours NOC_MUX_RR_OUTREG_EN (expected latency 1 instead of 0).
// -----------------------------------------------------------------------------
module tb_noc_mux_rr;
    import noc_mux_rr_pkg::*;

    localparam int FW = 32;
    localparam int CH = 4;
    localparam int IW = 2;
`ifdef NOC_MUX_RR_OUTREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic               clk;
    logic               rst_n;
    logic [CH*FW-1:0]   in_flit;
    logic [CH-1:0]      in_last;
    logic [CH-1:0]      in_valid;
    logic [CH-1:0]      in_ready;
    logic [FW-1:0]      out_flit;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;
    logic [IW-1:0]      active_ch;

    typedef struct packed {
        logic [FW-1:0] flit;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t        sb[$];
    logic [FW:0] src_mem [CH][64];
    int          src_wr  [CH];
    int          src_rd  [CH];
    int          n_pass;
    int          n_total;
    int          cyc;
    int          c;

    noc_mux_rr #(.FLIT_WIDTH(FW), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .active_ch (active_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required normal finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic logic [FW-1:0] mk(input int scen, input int ch, input int seq);
        return FW'(32'hA000_0000) | (FW'(scen) << 16) | (FW'(ch) << 8) | FW'(seq);
    endfunction

    task automatic load_pkt(input int ch, input int scen, input int n, input int seq0);
        for (int k = 0; k < n; k++) begin
            src_mem[ch][src_wr[ch] % 64] = {(k == n - 1), mk(scen, ch, seq0 + k)};
            src_wr[ch]++;
        end
    endtask

    task automatic expect_beat(input logic [FW-1:0] f, input logic l, input int cy);
        exp_t e;
        e.flit = f;
        e.last = l;
        e.cyc  = cy;
        sb.push_back(e);
    endtask

    // cy0 < 0 means the cycle of arrival is not checked.
    task automatic expect_pkt(input int ch, input int scen, input int n, input int seq0, input int cy0);
        for (int k = 0; k < n; k++) begin
            expect_beat(mk(scen, ch, seq0 + k), (k == n - 1), (cy0 < 0) ? -1 : cy0 + k);
        end
    endtask

    task automatic flush_src();
        for (int i = 0; i < CH; i++) src_rd[i] = src_wr[i];
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({"drain_", name}, 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flush_src();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Source models: pop on handshake, present the head of each channel queue.
    initial begin
        logic [CH-1:0] fire;
        in_valid = '0;
        in_last  = '0;
        in_flit  = '0;
        forever begin
            @(negedge clk);
            fire = in_valid & in_ready & {CH{rst_n}};
            @(posedge clk);
            #1;
            for (int i = 0; i < CH; i++) begin
                if (fire[i] && src_rd[i] != src_wr[i]) src_rd[i]++;
                if (src_rd[i] != src_wr[i]) begin
                    {in_last[i], in_flit[i*FW +: FW]} = src_mem[i][src_rd[i] % 64];
                    in_valid[i] = 1'b1;
                end else begin
                    in_last[i]         = 1'b0;
                    in_flit[i*FW +: FW] = '0;
                    in_valid[i]        = 1'b0;
                end
            end
        end
    end

    // Monitor: compare every output handshake against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_out: got flit %0h, required no output", out_flit);
                end else begin
                    e = sb.pop_front();
                    check("out_flit", 64'(out_flit), 64'(e.flit));
                    check("out_last", 64'(out_last), 64'(e.last));
                    if (e.cyc >= 0) check("out_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        logic [FW-1:0] held;
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < CH; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end

        // Reset state, with an input valid while reset is held.
        repeat (2) @(negedge clk);
        load_pkt(0, 0, 1, 1);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_active_ch", 64'(active_ch), 64'd0);
        check("rst_state", 64'(dut.r_state), 64'(IDLE));
        check("rst_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);
        flush_src();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_in_ready", 64'(in_ready), 64'd0);

        // A: ch0 and ch2 3-flit packets back to back.
        @(negedge clk);
        c = cyc;
        load_pkt(0, 1, 3, 1);
        load_pkt(2, 1, 3, 1);
        expect_pkt(0, 1, 3, 1, c + 1 + LAT);
        expect_pkt(2, 1, 3, 1, c + 4 + LAT);
        wait_drain("A");
        check("A_rr_ptr", 64'(dut.r_rr_ptr), 64'd3);
        check("A_state", 64'(dut.r_state), 64'(IDLE));
        check("A_active_ch", 64'(active_ch), 64'd2);

        // B: ch1 4-flit packet; ch0 becomes valid after flit 1 and must wait.
        @(negedge clk);
        c = cyc;
        load_pkt(1, 2, 4, 1);
        expect_pkt(1, 2, 4, 1, c + 1 + LAT);
        expect_pkt(0, 2, 2, 1, c + 5 + LAT);
        @(negedge clk);
        load_pkt(0, 2, 2, 1);
        repeat (3) begin
            @(negedge clk);
            check("B_ch0_blocked", 64'(in_ready), 64'b0010);
        end
        @(negedge clk);
        check("B_ch0_granted", 64'(in_ready), 64'b0001);
        wait_drain("B");
        check("B_rr_ptr", 64'(dut.r_rr_ptr), 64'd1);

        // C: out_ready low for 5 cycles in the middle of a ch3 packet.
        @(negedge clk);
        load_pkt(3, 3, 3, 1);
        expect_pkt(3, 3, 3, 1, -1);
        expect_pkt(0, 3, 1, 1, -1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = (LAT == 1) ? mk(3, 3, 1) : mk(3, 3, 2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("C_out_valid", 64'(out_valid), 64'd1);
            check("C_out_flit_held", 64'(out_flit), 64'(held));
            check("C_lock_state", 64'(dut.r_state), 64'(LOCKED));
            if (LAT == 0 || k > 0) check("C_in_ready", 64'(in_ready), 64'd0);
            if (k == 0) load_pkt(0, 3, 1, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain("C");
        check("C_rr_ptr", 64'(dut.r_rr_ptr), 64'd1);

        // D: continuous single-flit packets on all channels from rr_ptr=0.
        do_reset();
        @(negedge clk);
        c = cyc;
        load_pkt(0, 4, 1, 1);
        load_pkt(0, 4, 1, 2);
        for (int i = 1; i < CH; i++) load_pkt(i, 4, 1, 1);
        expect_pkt(0, 4, 1, 1, c + 1 + LAT);
        expect_pkt(1, 4, 1, 1, c + 2 + LAT);
        expect_pkt(2, 4, 1, 1, c + 3 + LAT);
        expect_pkt(3, 4, 1, 1, c + 4 + LAT);
        expect_pkt(0, 4, 1, 2, c + 5 + LAT);
        wait_drain("D");
        check("D_rr_ptr", 64'(dut.r_rr_ptr), 64'd1);

        // E: reset pulse during flit 2 of a ch1 4-flit packet.
        @(negedge clk);
        c = cyc;
        load_pkt(1, 5, 4, 1);
        expect_beat(mk(5, 1, 1), 1'b0, c + 1 + LAT);
        if (LAT == 0) expect_beat(mk(5, 1, 2), 1'b0, c + 2);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("E_out_valid", 64'(out_valid), 64'd0);
        check("E_in_ready", 64'(in_ready), 64'd0);
        check("E_state", 64'(dut.r_state), 64'(IDLE));
        check("E_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);
        check("E_active_ch", 64'(active_ch), 64'd0);
        flush_src();
        @(negedge clk);
        rst_n = 1'b1;
        check("E_sb_empty", 64'(sb.size()), 64'd0);
        @(negedge clk);
        check("E_post_out_valid", 64'(out_valid), 64'd0);
        check("E_post_state", 64'(dut.r_state), 64'(IDLE));
        @(negedge clk);
        c = cyc;
        load_pkt(2, 5, 1, 1);
        expect_pkt(2, 5, 1, 1, c + 1 + LAT);
        wait_drain("E");
        check("E_final_rr_ptr", 64'(dut.r_rr_ptr), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_noc_mux_rr
